// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls, MEM-stage
// redirects, multi-cycle data-memory freezes, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [1:0]       pc_src,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned WCNT_W = (TO_W > 8) ? TO_W : 8;

    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_MEM_WAIT = 1'b1;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    logic [0:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic taken;
    logic load_use;
    logic redirect;

    // Hazard detection terms
    always_comb begin
        freeze   = mem_req & ~dmem_ready;
        taken    = mem_jump | (mem_branch & mem_zero);
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

    // Prioritised control outputs: reset, freeze, redirect, load-use, normal
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        pc_src       = PC_SEQ;
        redirect     = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (taken) begin
            redirect    = 1'b1;
            pc_src      = mem_jump ? PC_JMP : PC_BR;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Wait FSM; the freeze itself is decoded from the handshake, the FSM only times it
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        if (state_q == S_MEM_WAIT) begin
            if (!mem_req || dmem_ready) begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end else begin
                if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
                if (wcnt_q >= WCNT_W'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                end
            end
        end else begin
            wcnt_d = '0;
            if (freeze) begin
                state_d = S_MEM_WAIT;
                wcnt_d  = WCNT_W'(1);
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard;
// small counter width and timeout make saturation and mem_err reachable quickly.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 4;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, exmem_flush, memwb_bubble}
    localparam logic [7:0] C_NORM = 8'b1111_0000;
    localparam logic [7:0] C_RST  = 8'b0000_1111;
    localparam logic [7:0] C_FRZ  = 8'b0000_0001;
    localparam logic [7:0] C_RED  = 8'b1111_1110;
    localparam logic [7:0] C_LU   = 8'b0011_0100;

    typedef struct packed {
        logic       rst;
        logic       mreq;
        logic       rdy;
        logic       br;
        logic       z;
        logic       j;
        logic       emr;
        logic [4:0] erd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
    } vin_t;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read;
    logic             mem_branch, mem_zero, mem_jump, mem_req, dmem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_bubble;
    logic [1:0]       pc_src;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .pc_src(pc_src),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vin_t mk(input logic r, input logic mreq, input logic rdy,
                                input logic br, input logic z, input logic j,
                                input logic emr, input logic [4:0] erd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        vin_t v;
        v.rst = r; v.mreq = mreq; v.rdy = rdy; v.br = br; v.z = z; v.j = j;
        v.emr = emr; v.erd = erd; v.rs = rs; v.rt = rt; v.urt = urt;
        return v;
    endfunction

    task automatic apply(input vin_t v);
        rst         = v.rst;
        mem_req     = v.mreq;
        dmem_ready  = v.rdy;
        mem_branch  = v.br;
        mem_zero    = v.z;
        mem_jump    = v.j;
        ex_mem_read = v.emr;
        ex_rd       = v.erd;
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_uses_rt  = v.urt;
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic vec(input vin_t v, input logic [7:0] ctl, input logic [1:0] src,
                       input logic err, input int sc, input int fc, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.v    = {ctl, src, err, 3'(sc), 3'(fc)};
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t        e;
                logic [16:0] act;
                e   = exp_q.pop_front();
                act = {pc_write, ifid_write, idex_write, exmem_write,
                       ifid_flush, idex_flush, exmem_flush, memwb_bubble,
                       pc_src, mem_err, stall_cnt, flush_cnt};
                n_tests++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%b src=%b err=%b sc=%0d fc=%0d, expected ctl=%b src=%b err=%b sc=%0d fc=%0d",
                             e.name, act[16:9], act[8:7], act[6], act[5:3], act[2:0],
                             e.v[16:9], e.v[8:7], e.v[6], e.v[5:3], e.v[2:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vin_t idle, junk, lu8, frz, done;
        int   guard;
        idle = mk(L, L, L, L, L, L, L, 5'd0, 5'd0, 5'd0, L);
        junk = mk(H, H, L, H, H, H, H, 5'd8, 5'd8, 5'd8, H);
        lu8  = mk(L, L, L, L, L, L, H, 5'd8, 5'd8, 5'd0, L);
        frz  = mk(L, H, L, L, L, L, L, 5'd0, 5'd0, 5'd0, L);
        done = mk(L, H, H, L, L, L, L, 5'd0, 5'd0, 5'd0, L);
        apply(junk);

        // Reset with busy inputs, then release
        @(posedge clk);
        #1;
        apply(junk);
        vec(junk, C_RST, 2'b00, L, 0, 0, "reset_1");
        vec(junk, C_RST, 2'b00, L, 0, 0, "reset_2");
        vec(idle, C_NORM, 2'b00, L, 0, 0, "post_reset_idle");

        // Load-use
        vec(lu8, C_LU, 2'b00, L, 0, 0, "load_use_rs");
        vec(idle, C_NORM, 2'b00, L, 1, 0, "load_use_one_cycle");
        vec(mk(L, L, L, L, L, L, H, 5'd0, 5'd0, 5'd0, L), C_NORM, 2'b00, L, 1, 0, "load_use_rd0");
        vec(mk(L, L, L, L, L, L, H, 5'd9, 5'd3, 5'd9, H), C_LU, 2'b00, L, 1, 0, "load_use_rt");
        vec(mk(L, L, L, L, L, L, H, 5'd9, 5'd3, 5'd9, L), C_NORM, 2'b00, L, 2, 0, "load_use_rt_unused");

        // Redirects
        vec(mk(L, L, L, H, H, L, L, 5'd0, 5'd0, 5'd0, L), C_RED, 2'b01, L, 2, 0, "branch_taken");
        vec(idle, C_NORM, 2'b00, L, 2, 1, "after_branch");
        vec(mk(L, L, L, H, H, H, L, 5'd0, 5'd0, 5'd0, L), C_RED, 2'b10, L, 2, 1, "jump_over_branch");
        vec(mk(L, L, L, H, L, L, L, 5'd0, 5'd0, 5'd0, L), C_NORM, 2'b00, L, 2, 2, "branch_not_taken");
        vec(mk(L, L, L, L, L, H, H, 5'd8, 5'd8, 5'd0, L), C_RED, 2'b10, L, 2, 2, "jump_beats_load_use");
        vec(idle, C_NORM, 2'b00, L, 2, 3, "after_jump");
        vec(mk(H, L, L, L, L, L, L, 5'd0, 5'd0, 5'd0, L), C_RST, 2'b00, L, 2, 3, "reset_clear");

        // Three-cycle memory wait
        vec(frz, C_FRZ, 2'b00, L, 0, 0, "mem_wait_1");
        vec(frz, C_FRZ, 2'b00, L, 1, 0, "mem_wait_2");
        vec(frz, C_FRZ, 2'b00, L, 2, 0, "mem_wait_3");
        vec(done, C_NORM, 2'b00, L, 3, 0, "mem_ready");
        vec(done, C_NORM, 2'b00, L, 3, 0, "mem_zero_wait");
        vec(idle, C_NORM, 2'b00, L, 3, 0, "mem_idle");

        // Timeout (stall_cnt saturates at 7 along the way)
        vec(frz, C_FRZ, 2'b00, L, 3, 0, "timeout_w0");
        vec(frz, C_FRZ, 2'b00, L, 4, 0, "timeout_w1");
        vec(frz, C_FRZ, 2'b00, L, 5, 0, "timeout_w2");
        vec(frz, C_FRZ, 2'b00, L, 6, 0, "timeout_w3");
        vec(frz, C_FRZ, 2'b00, L, 7, 0, "timeout_w4");
        vec(frz, C_FRZ, 2'b00, H, 7, 0, "timeout_err_set");
        vec(done, C_NORM, 2'b00, H, 7, 0, "err_sticky_ready");
        vec(frz, C_FRZ, 2'b00, H, 7, 0, "err_sticky_rewait");
        vec(mk(H, H, L, L, L, L, L, 5'd0, 5'd0, 5'd0, L), C_RST, 2'b00, H, 7, 0, "reset_mid_wait");
        vec(idle, C_NORM, 2'b00, L, 0, 0, "after_reset_mid_wait");

        // Redirect deferred behind a pending access
        vec(mk(L, H, L, H, H, L, L, 5'd0, 5'd0, 5'd0, L), C_FRZ, 2'b00, L, 0, 0, "freeze_over_branch_1");
        vec(mk(L, H, L, H, H, L, L, 5'd0, 5'd0, 5'd0, L), C_FRZ, 2'b00, L, 1, 0, "freeze_over_branch_2");
        vec(mk(L, H, H, H, H, L, L, 5'd0, 5'd0, 5'd0, L), C_RED, 2'b01, L, 2, 0, "branch_on_ready");
        vec(idle, C_NORM, 2'b00, L, 2, 1, "after_deferred_branch");

        // mem_req dropped mid-wait
        vec(frz, C_FRZ, 2'b00, L, 2, 1, "drop_req_wait");
        vec(idle, C_NORM, 2'b00, L, 3, 1, "drop_req_released");
        vec(idle, C_NORM, 2'b00, L, 3, 1, "drop_req_idle");

        // Stall counter saturation via repeated load-use
        for (int i = 0; i < 5; i++) begin
            vec(lu8, C_LU, 2'b00, L, (3 + i > 7) ? 7 : 3 + i, 1, $sformatf("sat_lu_%0d", i));
        end
        vec(idle, C_NORM, 2'b00, L, 7, 1, "stall_cnt_saturated");

        @(posedge clk);
        #1;
        apply(idle);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It covers three cases: load-use hazards, control redirects resolved in the MEM stage (branch/jump fields carried by EX/MEM), and multi-cycle data-memory accesses. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
- `CNT_W`, 16, width of the performance counters
- `MEM_TIMEOUT`, 255, number of MEM_WAIT cycles before `mem_err` is set
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_rs`, `id_rt`  in  5 each  source register fields of the instruction in ID
- `id_uses_rt`  in  1  ID instruction reads rt
- `ex_mem_read`, `ex_rd`  in  1, 5  ID/EX outputs: instruction in EX is a load, and its destination register
- `mem_branch`, `mem_zero`, `mem_jump`  in  1 each  EX/MEM outputs: branch, zero flag, jump
- `mem_req`  in  1  MEM stage performs a data-memory read or write
- `dmem_ready`  in  1  data memory completes the access this cycle
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write`  out  1 each  register load enables
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_bubble`  out  1 each  insert a NOP into that buffer
- `pc_src`  out  2  00 = PC+4, 01 = branch target, 10 = jump address
- `mem_err`  out  1  sticky memory-timeout flag
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating performance counters

## Operation
- FSM states: RUN and MEM_WAIT. A wait counter `wcnt` (8 bits minimum, wide enough for MEM_TIMEOUT) runs alongside the FSM.
- Control outputs are combinational from the state and the inputs.
- Counters, `mem_err` and the state are registered.
- Outputs evaluate in priority order; the first matching condition wins.
  1. Reset (`rst`=1): all write enables 0; all flushes and `memwb_bubble` 1; `pc_src`=00.
  2. Memory freeze, when `mem_req`=1 and `dmem_ready`=0:
     - `pc_write`, `ifid_write`, `idex_write`, `exmem_write` all 0.
     - `memwb_bubble`=1; other flushes 0; `pc_src`=00.
  3. Redirect, when taken = `mem_jump` OR (`mem_branch` AND `mem_zero`):
     - `pc_src`=10 if `mem_jump`=1, otherwise 01. Jump wins if both are set.
     - `pc_write`=1.
     - `ifid_flush`, `idex_flush`, `exmem_flush` all 1. This squashes 3 wrong-path instructions.
     - Any load-use condition is ignored that cycle.
  4. Load-use, when `ex_mem_read`=1, `ex_rd`≠0, and (`ex_rd`==`id_rs` OR (`id_uses_rt` AND `ex_rd`==`id_rt`)):
     - `pc_write`=0, `ifid_write`=0, `idex_flush`=1.
     - All other enables 1.
  5. Normal: all write enables 1, all flushes 0, `pc_src`=00.
- FSM transitions:
  - RUN → MEM_WAIT when `mem_req`=1 and `dmem_ready`=0; `wcnt` is loaded with 1.
  - MEM_WAIT → RUN when `dmem_ready`=1. In that cycle the outputs follow priorities 3–5, because the access is complete.
  - MEM_WAIT stays in MEM_WAIT while `dmem_ready`=0; `wcnt` increments and saturates.
  - When `wcnt` reaches MEM_TIMEOUT, `mem_err` is set to 1 and stays set until `rst`. The freeze continues.
  - If `mem_req` drops to 0 while in MEM_WAIT, return to RUN. This is a protocol violation but must not hang.
- Counters:
  - `stall_cnt` increments every non-reset cycle with `pc_write`=0.
  - `flush_cnt` increments every non-reset cycle in which a redirect is taken.
  - Both saturate at 2^CNT_W−1; they do not wrap.

## Timing
- Reset:
  - Takes effect on the first rising edge with `rst`=1.
  - State = RUN, `wcnt`=0, `mem_err`=0, both counters 0.
  - A reset during MEM_WAIT aborts the wait; the first cycle after reset is RUN.
- Latency: control outputs respond in the same cycle as their inputs (0-cycle). State, counter and flag updates become visible one cycle later.
- Load-use stall lasts exactly 1 cycle. On the next edge the load moves to MEM, so `ex_mem_read` no longer matches.
- Branch penalty is 3 cycles. The redirect is asserted for 1 cycle; the pipeline must deassert `mem_branch`/`mem_jump` afterwards, because EX/MEM is flushed.
- Memory handshake:
  - The access completes on the edge where `mem_req`=1 and `dmem_ready`=1.
  - A zero-wait access (`dmem_ready`=1 in the same cycle as `mem_req`) causes no stall and no state change.
- Simultaneous events:
  - Freeze + redirect: the redirect is deferred to the `dmem_ready` cycle.
  - Redirect + load-use: flush only; the load-use stall is not counted.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random inputs → `pc_write`=0, all flushes 1, `pc_src`=00, counters 0, `mem_err`=0. After release with idle inputs → all enables 1, flushes 0.
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8 for 1 cycle → `pc_write`=`ifid_write`=0 and `idex_flush`=1 for exactly 1 cycle; `stall_cnt`=1. Repeat with `ex_rd`=0 → no stall.
- Branch: `mem_branch`=1, `mem_zero`=1 → `pc_src`=01, three flushes =1, `pc_write`=1, `flush_cnt`=1. With `mem_jump`=1 also set → `pc_src`=10. With `mem_zero`=0 → no redirect.
- Memory wait: `mem_req`=1, `dmem_ready`=0 for 3 cycles, then 1 → freeze and `memwb_bubble`=1 for 3 cycles, normal on the 4th; state returns to RUN; `stall_cnt`=3.
- Timeout and reset: with MEM_TIMEOUT=4, hold `dmem_ready`=0 for 6 cycles → `mem_err`=1 from the cycle after `wcnt`=4. Assert `rst` mid-wait → state RUN and `mem_err`=0 after that edge.
- Saturation and priority: with CNT_W=2, produce 5 stalls → `stall_cnt`=3. Apply a redirect while a memory access is pending → `pc_src`=00 until `dmem_ready`=1, then redirect.
